// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART transmit definitions: FSM states, format codes and format decode helpers.
// No logic of its own; imported by the serializer and its baud timer.
// Pure functions only, so there is no latency and no backpressure.
package uart_tx_serializer_pkg;

  // Frame sequencer states; IDLE is the only state that accepts a byte.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity selection codes on i_check_bit; 2'b11 also means no parity.
  localparam logic [1:0] CHK_NONE = 2'b00;
  localparam logic [1:0] CHK_ODD  = 2'b01;
  localparam logic [1:0] CHK_EVEN = 2'b10;

  // Stop-bit codes on i_stop_bit; every code other than STOP_ONE gives two stop bits.
  localparam logic [1:0] STOP_ONE = 2'b00;
  localparam logic [1:0] STOP_TWO = 2'b01;

  localparam int UART_DATA_W = 8;

  // Number of data bits minus one (the data-bit index start value).
  // Only 5..8 are legal widths; anything else falls back to 8 bits.
  function automatic logic [2:0] data_bits_m1(input logic [3:0] data_bit);
    logic [2:0] nbits_m1;
    case (data_bit)
      4'd5:    nbits_m1 = 3'd4;
      4'd6:    nbits_m1 = 3'd5;
      4'd7:    nbits_m1 = 3'd6;
      default: nbits_m1 = 3'd7;
    endcase
    return nbits_m1;
  endfunction

  // True when the check code asks for a parity bit in the frame.
  function automatic logic has_parity(input logic [1:0] check_bit);
    return (check_bit == CHK_ODD) || (check_bit == CHK_EVEN);
  endfunction

  // Parity bit over the data bits actually sent; bits above the width are ignored.
  // Even parity is the plain XOR, odd parity its inverse.
  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                       input logic [2:0] nbits_m1,
                                       input logic [1:0] check_bit);
    logic par;
    par = (check_bit == CHK_ODD);
    for (int i = 0; i < UART_DATA_W; i++) begin
      if (3'(i) <= nbits_m1) begin
        par = par ^ data[i];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte stream between the TX byte FIFO read side and the serial transmit engine.
// Combinational bundle, no latency of its own.
// Valid/ready: a byte moves on a cycle where tx_valid and tx_ready are both high.
interface uart_tx_serializer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // FIFO side: offers bytes.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmit engine side: takes bytes when it is idle.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_serializer_baud_tick.sv
// Loadable bit-period down-counter; flags the last clock of the current bit.
// A load takes effect on the next edge; o_bit_end is combinational from the count.
// No backpressure: the owner loads it whenever a new bit period begins.
module uart_tx_serializer_baud_tick #(
  parameter int P_DIV_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic [P_DIV_WIDTH-1:0] i_load_val,
  output logic                   o_bit_end
);

  logic [P_DIV_WIDTH-1:0] r_cnt;

  // Count down from the loaded value and park at zero until reloaded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - P_DIV_WIDTH'(1);
    end
  end

  assign o_bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// Serial transmit engine: frames one byte as start, data LSB first, optional parity, stop.
// Start bit drives from the accepting edge; each bit lasts div clocks; one idle clock between frames.
// Ready only in IDLE (gated by synchronized CTS when UART_TX_CTS_EN is defined); valid is ignored while busy.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int P_DIV_WIDTH = 24,
  parameter int P_CTS_SYNC  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_tx_serializer_if.slave    s_tx,
  input  logic [P_DIV_WIDTH-1:0] i_div_num,
  input  logic [3:0]             i_data_bit,
  input  logic [1:0]             i_stop_bit,
  input  logic [1:0]             i_check_bit,
  input  logic                   i_uart_cts,
  output logic                   o_uart_tx,
  output logic                   o_busy
);

  // Frame state and the format latched at accept time.
  tx_state_t              r_state;
  logic                   r_line;
  logic [UART_DATA_W-1:0] r_shift;
  logic [2:0]             r_idx;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_stop_two;
  logic [P_DIV_WIDTH-1:0] r_div_m1;

  // Sequencer decisions for the coming edge.
  tx_state_t              w_state_nxt;
  logic                   w_line_nxt;
  logic                   w_load;
  logic [P_DIV_WIDTH-1:0] w_load_val;
  logic                   w_shift;
  logic                   w_stop_clr;
  logic                   w_accept;
  logic                   w_bit_end;
  logic                   w_cts_clear;
  logic [P_DIV_WIDTH-1:0] w_div_m1_in;
  logic [2:0]             w_nbits_m1_in;

`ifdef UART_TX_CTS_EN
  // CTS is an asynchronous, active-low pin; it resets to "not clear".
  logic [P_CTS_SYNC-1:0] r_cts_sync;

  // Synchronize CTS into the clock domain; only the last stage is used.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cts_sync <= '1;
    end else begin
      r_cts_sync <= (r_cts_sync << 1) | P_CTS_SYNC'(i_uart_cts);
    end
  end

  // CTS only gates the start of a frame; a frame already running completes.
  assign w_cts_clear = ~r_cts_sync[P_CTS_SYNC-1];
`else
  // Flow control is not built in: the pin and its synchronizer depth are deliberately unused.
  logic [31:0] w_unused_cts;
  assign w_unused_cts = {31'(P_CTS_SYNC), i_uart_cts};
  assign w_cts_clear  = 1'b1;
`endif

  // Ready is dropped during the reset cycle and whenever a frame is in flight.
  assign s_tx.tx_ready = (r_state == ST_IDLE) & reset & w_cts_clear;
  assign w_accept      = s_tx.tx_valid & s_tx.tx_ready;

  // Divider values below 2 run at 2 clocks per bit; the counter runs div-1 down to 0.
  assign w_div_m1_in   = (i_div_num < P_DIV_WIDTH'(2)) ? P_DIV_WIDTH'(1)
                                                       : (i_div_num - P_DIV_WIDTH'(1));
  assign w_nbits_m1_in = data_bits_m1(i_data_bit);

  uart_tx_serializer_baud_tick #(
    .P_DIV_WIDTH (P_DIV_WIDTH)
  ) u_baud_tick (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_bit_end  (w_bit_end)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next line level and bit-timer/shift controls.
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = 1'b1;
    w_load      = 1'b0;
    w_load_val  = r_div_m1;
    w_shift     = 1'b0;
    w_stop_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // Divider is taken straight from the port since it is being latched on this edge.
          w_state_nxt = ST_START;
          w_line_nxt  = 1'b0;
          w_load      = 1'b1;
          w_load_val  = w_div_m1_in;
        end
      end
      ST_START: begin
        w_line_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_line_nxt  = r_shift[0];
          w_load      = 1'b1;
        end
      end
      ST_DATA: begin
        w_line_nxt = r_shift[0];
        if (w_bit_end) begin
          w_load = 1'b1;
          if (r_idx != 3'd0) begin
            w_shift    = 1'b1;
            w_line_nxt = r_shift[1];
          end else if (r_par_en) begin
            w_state_nxt = ST_PARITY;
            w_line_nxt  = r_par_bit;
          end else begin
            w_state_nxt = ST_STOP;
            w_line_nxt  = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        w_line_nxt = r_par_bit;
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_line_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      ST_STOP: begin
        w_line_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_stop_two) begin
            // First of two stop bits done; time one more period.
            w_stop_clr = 1'b1;
            w_load     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered line plus the per-frame datapath: latch on accept, then shift and count down.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_line     <= 1'b1;
      r_shift    <= '0;
      r_idx      <= 3'd0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_two <= 1'b0;
      r_div_m1   <= '0;
    end else begin
      r_line <= w_line_nxt;
      if (w_accept) begin
        r_shift    <= s_tx.tx_data;
        r_idx      <= w_nbits_m1_in;
        r_par_en   <= has_parity(i_check_bit);
        r_par_bit  <= calc_parity(s_tx.tx_data, w_nbits_m1_in, i_check_bit);
        r_stop_two <= (i_stop_bit != STOP_ONE);
        r_div_m1   <= w_div_m1_in;
      end else begin
        if (w_shift) begin
          r_shift <= r_shift >> 1;
          r_idx   <= r_idx - 3'd1;
        end
        if (w_stop_clr) begin
          r_stop_two <= 1'b0;
        end
      end
    end
  end

  assign o_uart_tx = r_line;
  assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for the UART transmit serializer: directed format cases plus randomized frames.
// A per-clock queue of expected line levels is built from the frame rules at each accept.
// Ready, busy and the line are compared every clock on the falling edge.
module tb_uart_tx_serializer;

  localparam int DIV_W    = 24;
  localparam int CTS_SYNC = 2;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic [DIV_W-1:0] div_num   = 24'd4;
  logic [3:0]       data_bit  = 4'd8;
  logic [1:0]       stop_bit  = 2'b00;
  logic [1:0]       check_bit = 2'b00;
  logic             uart_cts  = 1'b0;
  logic             uart_tx;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  bit line_q[$];
`ifdef UART_TX_CTS_EN
  logic [CTS_SYNC:0] cts_hist = '1;
`endif

  uart_tx_serializer_if tx_if();

  always #5 clock = ~clock;

  uart_tx_serializer #(
    .P_DIV_WIDTH (DIV_W),
    .P_CTS_SYNC  (CTS_SYNC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .s_tx        (tx_if),
    .i_div_num   (div_num),
    .i_data_bit  (data_bit),
    .i_stop_bit  (stop_bit),
    .i_check_bit (check_bit),
    .i_uart_cts  (uart_cts),
    .o_uart_tx   (uart_tx),
    .o_busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_bits(input bit b, input int clocks);
    for (int k = 0; k < clocks; k++) line_q.push_back(b);
  endtask

  // Expected waveform of one frame from the currently driven byte and format.
  task automatic push_frame();
    logic [7:0] v;
    int n, d, nstop;
    bit par;
    v     = tx_if.tx_data;
    n     = (data_bit >= 4'd5 && data_bit <= 4'd8) ? int'(data_bit) : 8;
    d     = (div_num < 24'd2) ? 2 : int'(div_num);
    nstop = (stop_bit == 2'b00) ? 1 : 2;
    par   = (check_bit == 2'b01);
    for (int i = 0; i < n; i++) par = par ^ v[i];
    push_bits(1'b0, d);
    for (int i = 0; i < n; i++) push_bits(v[i], d);
    if (check_bit == 2'b01 || check_bit == 2'b10) push_bits(par, d);
    push_bits(1'b1, nstop * d);
  endtask

  // Per-clock comparison and model advance.
  always @(negedge clock) begin
    bit cts_ok;
    bit exp_ready;
    bit exp_line;
`ifdef UART_TX_CTS_EN
    cts_hist[0] = uart_cts;
    cts_ok      = !cts_hist[CTS_SYNC];
`else
    cts_ok      = 1'b1;
`endif
    exp_ready = (line_q.size() == 0) && reset && cts_ok;
    exp_line  = (line_q.size() != 0) ? line_q[0] : 1'b1;
    check_eq("tx_ready", 32'(tx_if.tx_ready), 32'(exp_ready));
    check_eq("uart_tx", 32'(uart_tx), 32'(exp_line));
    check_eq("busy", 32'(busy), 32'(line_q.size() != 0));
    if (!reset) begin
      line_q.delete();
    end else if (line_q.size() != 0) begin
      void'(line_q.pop_front());
    end else if (exp_ready && tx_if.tx_valid) begin
      push_frame();
      accepted++;
    end
`ifdef UART_TX_CTS_EN
    cts_hist = {cts_hist[CTS_SYNC-1:0], 1'b0};
    if (!reset) cts_hist = '1;
`endif
  end

  // Offer a byte, wait for the model to take it, then scramble the format mid-frame.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] db, input logic [1:0] sb,
                           input logic [1:0] cb, input logic [DIV_W-1:0] dv, input bit keep_valid);
    int start;
    int n;
    tx_if.tx_data  = d;
    data_bit       = db;
    stop_bit       = sb;
    check_bit      = cb;
    div_num        = dv;
    tx_if.tx_valid = 1'b1;
    start = accepted;
    n = 0;
    while (accepted == start && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check_eq("accept_timeout", 32'(n < 2000), 32'd1);
    #1;
    if (!keep_valid) tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'($urandom);
    data_bit      = 4'($urandom);
    stop_bit      = 2'($urandom);
    check_bit     = 2'($urandom);
    div_num       = DIV_W'($urandom_range(0, 6));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (line_q.size() != 0 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    check_eq("idle_timeout", 32'(n < 5000), 32'd1);
    #1;
  endtask

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // 8N1, 7E1, 8O2 at div 4
    send_byte(8'h55, 4'd8, 2'b00, 2'b00, 24'd4, 1'b0); wait_idle();
    send_byte(8'h41, 4'd7, 2'b00, 2'b10, 24'd4, 1'b0); wait_idle();
    send_byte(8'hFF, 4'd8, 2'b01, 2'b01, 24'd4, 1'b0); wait_idle();

    // Back-to-back with valid held
    send_byte(8'hA5, 4'd8, 2'b00, 2'b00, 24'd4, 1'b1);
    send_byte(8'h3C, 4'd8, 2'b00, 2'b00, 24'd4, 1'b0); wait_idle();

    // Divider clamp and odd widths
    send_byte(8'h96, 4'd6, 2'b11, 2'b01, 24'd1, 1'b0); wait_idle();
    send_byte(8'h2B, 4'd5, 2'b00, 2'b10, 24'd0, 1'b0); wait_idle();
    send_byte(8'hC3, 4'd12, 2'b10, 2'b11, 24'd3, 1'b0); wait_idle();

    // Reset during data bit 3, then a clean frame
    send_byte(8'h00, 4'd8, 2'b00, 2'b00, 24'd4, 1'b0);
    repeat (17) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    send_byte(8'h12, 4'd8, 2'b00, 2'b00, 24'd4, 1'b0); wait_idle();

`ifdef UART_TX_CTS_EN
    begin
      int start;
      int n;
      uart_cts       = 1'b1;
      tx_if.tx_data  = 8'h5A;
      data_bit       = 4'd8;
      stop_bit       = 2'b00;
      check_bit      = 2'b00;
      div_num        = 24'd4;
      tx_if.tx_valid = 1'b1;
      repeat (100) @(posedge clock);
      #1;
      check_eq("cts_blocked", 32'(accepted), 32'(10));
      start    = accepted;
      uart_cts = 1'b0;
      n = 0;
      while (accepted == start && n < 50) begin
        @(posedge clock);
        n++;
      end
      check_eq("cts_accept_lat", 32'(n <= CTS_SYNC + 1), 32'd1);
      #1 tx_if.tx_valid = 1'b0;
      wait_idle();
    end
`endif

    // Randomized frames, gaps and held valid
    for (int it = 0; it < 40; it++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        tx_if.tx_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
`ifndef UART_TX_CTS_EN
      uart_cts = 1'($urandom);
`endif
      send_byte(8'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                DIV_W'($urandom_range(0, 6)), ($urandom_range(0, 2) == 0));
    end
    tx_if.tx_valid = 1'b0;
    wait_idle();
    check_eq("frames_accepted", 32'(accepted), 32'(`ifdef UART_TX_CTS_EN 51 `else 50 `endif));
    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    check_eq("watchdog", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
